cameralink_n_x_7to1_sdr_tx: RTL and testbench
=============================================

# cameralink_n_x_7to1_sdr_tx

Parallel-to-serial CameraLink transmitter. It is the transmit-side counterpart of the `lvds_n_x_1to7_sdr_rx` deserializer. Pixel words are accepted through a valid/ready handshake into a 2-entry buffer and serialized 7:1 onto every data lane. The per-channel clock lane carries the 1100011 pattern. The block runs on the bit-rate clock and feeds the LVDS output buffers; its lane packing mirrors the receiver's `data_out`.

## Interface
Parameters:
- CAMERALINK_MODE, 2, number of channels (Base 1, Medium 2, Full 3)
- CAMERALINK_CHAL, 4, data lanes per channel
- UFLOW_CNT_W, 16, width of the underflow counter

Ports:
- ser_clk_in  input  1  bit-rate clock (7x pixel rate); the only clock
- reset_n  input  1  asynchronous, active-low reset
- tx_en  input  1  enable; when low, idle words are sent
- data_in  input  CAMERALINK_MODE*CAMERALINK_CHAL*7  pixel word; lane k occupies [7k+6:7k]
- data_valid  input  1  data_in is valid
- data_ready  output  1  buffer can accept a word
- data_out_ser  output  CAMERALINK_MODE*CAMERALINK_CHAL  serial bit per lane
- clk_out_ser  output  CAMERALINK_MODE  serial clock-lane bit per channel
- pixel_clk_en  output  1  one-cycle strobe per word
- underflow  output  1  sticky underflow flag
- underflow_cnt  output  UFLOW_CNT_W  saturating underflow count

## Operation
- **Buffer:** 2-entry FIFO (count 0..2).
  - data_ready = (count < 2), combinational from count.
  - A push occurs on an edge where data_valid && data_ready.
  - A pop may only take a word already stored before that edge; a word pushed at an edge is never popped at the same edge.
  - A simultaneous push and pop leaves count unchanged. Entry order is FIFO.
- **Phase counter:** 3 bits, counts 0,1,...,6,0. It never takes the value 7.
- **Word register word_q:** at the edge where phase==6, word_q is loaded as follows:
  - tx_en=1 and count>0: pop the FIFO head into word_q.
  - tx_en=1 and count==0: load the idle word (all zeros), set underflow, and increment underflow_cnt (saturates at all-ones).
  - tx_en=0: load the idle word. No pop and no underflow. The FIFO continues to accept words until full.
- **Serialization:** at every edge, data_out_ser[k] <= word_q[7k + 6 - phase]. The MSB of each lane goes first.
- **Clock lane:** at every edge, clk_out_ser[c] <= P[6 - phase], with P = 7'b1100011. All channels carry the same value.
- **pixel_clk_en:** pixel_clk_en <= (phase==0). It is high exactly in the cycle where bit 6 of a word is on the outputs.
- **Underflow flag:** underflow is cleared only by reset.

## Timing
- Reset (asynchronous assert) forces the following:
  - phase=0, word_q=0, FIFO count=0
  - data_out_ser=0, clk_out_ser=0, pixel_clk_en=0
  - underflow=0, underflow_cnt=0
  - data_ready=1 (combinational)
- Release is synchronized externally. First edge after release (phase 0): clk_out_ser=1, data_out_ser=0, pixel_clk_en=1.
- **Output stream:** one bit per lane per cycle. A word occupies 7 consecutive cycles. The clock lane repeats 1,1,0,0,0,1,1 with the word boundary aligned to pattern start.
- **Latency:** a word pushed at edge E is loaded at the first phase-6 edge strictly after E. Its bit 6 appears on the output after the following edge. Minimum is 2 cycles, maximum is 8 cycles, with an empty FIFO.
- **Throughput:** one word per 7 cycles. A continuously valid source sees data_ready drop once count reaches 2.
- A tx_en change takes effect only at a phase-6 edge. A word already in word_q always completes.
- Reset mid-word truncates the word immediately. Buffered words are discarded.

## Test plan
- **Reset values:** assert reset_n=0 mid-stream -> all outputs 0 and data_ready=1 immediately. After release, clk_out_ser sequence is 1,1,0,0,0,1,1 repeating and pixel_clk_en is high every 7th cycle starting from the first cycle.
- **Single word:** MODE=1, CHAL=4, push data_in=28'h5A_C3_F0_1 (lane0 = 7'b0000001) -> lane0 emits 0,0,0,0,0,0,1. All lanes match word bits MSB-first. Bit 6 appears 2–8 cycles after the push. underflow stays 0 only if the push lands before the next load.
- **Back-to-back:** hold data_valid=1 with an incrementing pattern for 20 words -> data_ready toggles with count, no word is lost or duplicated, and the receiver model recovers the identical sequence.
- **Underflow:** tx_en=1 with no data for 3 word periods -> 3 idle words on the lanes, underflow=1, underflow_cnt=3. With UFLOW_CNT_W=2, 5 underflows -> underflow_cnt saturates at 3.
- **Enable gating:** tx_en=0 while pushing 2 words -> data_ready=0 after 2 pushes, idle words on the lanes, no underflow. Raise tx_en -> both words are sent in order starting at the next boundary.
- **Full/simultaneous:** count=1 with a push on the same edge as the phase-6 pop -> count stays 1, and the popped word is the older one.

Source files
------------

// File: rtl/cameralink_n_x_7to1_sdr_tx.sv
// CameraLink 7:1 serializer: a 2-entry pixel FIFO feeds a word register that is
// shifted out MSB-first on every data lane, with a 1100011 clock lane per channel.
`timescale 1ns/1ps

module cameralink_n_x_7to1_sdr_tx #(
    parameter int CAMERALINK_MODE = 2,
    parameter int CAMERALINK_CHAL = 4,
    parameter int UFLOW_CNT_W     = 16
) (
    input  logic                                          ser_clk_in,
    input  logic                                          reset_n,
    input  logic                                          tx_en,
    input  logic [CAMERALINK_MODE*CAMERALINK_CHAL*7-1:0]  data_in,
    input  logic                                          data_valid,
    output logic                                          data_ready,
    output logic [CAMERALINK_MODE*CAMERALINK_CHAL-1:0]    data_out_ser,
    output logic [CAMERALINK_MODE-1:0]                    clk_out_ser,
    output logic                                          pixel_clk_en,
    output logic                                          underflow,
    output logic [UFLOW_CNT_W-1:0]                        underflow_cnt
);

    localparam int LANES = CAMERALINK_MODE * CAMERALINK_CHAL;
    localparam logic [6:0] CLK_PATTERN = 7'b1100011;
    localparam logic [UFLOW_CNT_W-1:0] CNT_ONE = 1;

    typedef logic [LANES-1:0][6:0] word_t;

    logic [2:0]       phase;
    logic [1:0]       count;
    word_t            slot0;
    word_t            slot1;
    word_t            word_q;
    logic             push;
    logic             pop;
    logic             load;
    logic             starve;
    logic [LANES-1:0] ser_bits;
    logic             clk_bit;

    // Selects the bit of a 7-bit lane word that goes out in the given phase.
    function automatic logic pick_bit(input logic [6:0] lane, input logic [2:0] ph);
        logic [2:0] idx;
        idx = 3'd6 - ph;
        return lane[idx];
    endfunction

    assign data_ready = (count < 2'd2);
    assign push       = data_valid && data_ready;
    assign load       = (phase == 3'd6);
    assign pop        = load && tx_en && (count != 2'd0);
    assign starve     = load && tx_en && (count == 2'd0);

    always_ff @(posedge ser_clk_in or negedge reset_n) begin
        if (!reset_n) begin
            count <= 2'd0;
        end else if (push && !pop) begin
            count <= count + 2'd1;
        end else if (pop && !push) begin
            count <= count - 2'd1;
        end
    end

    // Push together with pop only happens at count 1, so the new word becomes the head.
    always_ff @(posedge ser_clk_in) begin
        if (pop && push) begin
            slot0 <= data_in;
        end else if (pop) begin
            slot0 <= slot1;
        end else if (push) begin
            if (count == 2'd0) begin
                slot0 <= data_in;
            end else begin
                slot1 <= data_in;
            end
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign ser_bits[k] = pick_bit(word_q[k], phase);
    end

    assign clk_bit = pick_bit(CLK_PATTERN, phase);

    always_ff @(posedge ser_clk_in or negedge reset_n) begin
        if (!reset_n) begin
            phase        <= 3'd0;
            word_q       <= '0;
            data_out_ser <= '0;
            clk_out_ser  <= '0;
            pixel_clk_en <= 1'b0;
        end else begin
            phase <= load ? 3'd0 : phase + 3'd1;
            if (load) begin
                word_q <= pop ? slot0 : '0;
            end
            data_out_ser <= ser_bits;
            clk_out_ser  <= {CAMERALINK_MODE{clk_bit}};
            pixel_clk_en <= (phase == 3'd0);
        end
    end

    always_ff @(posedge ser_clk_in or negedge reset_n) begin
        if (!reset_n) begin
            underflow     <= 1'b0;
            underflow_cnt <= '0;
        end else if (starve) begin
            underflow <= 1'b1;
            if (underflow_cnt != '1) begin
                underflow_cnt <= underflow_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_cameralink_n_x_7to1_sdr_tx.sv
// Directed bench for the CameraLink 7:1 transmitter (one channel, four lanes,
// 2-bit underflow counter); a lane receiver model rebuilds words from the outputs.
`timescale 1ns/1ps

module tb_cameralink_n_x_7to1_sdr_tx;

    localparam int MODE  = 1;
    localparam int CHAL  = 4;
    localparam int UW    = 2;
    localparam int LANES = MODE * CHAL;
    localparam int W     = LANES * 7;

    logic                ser_clk_in = 1'b0;
    logic                reset_n;
    logic                tx_en;
    logic [W-1:0]        data_in;
    logic                data_valid;
    logic                data_ready;
    logic [LANES-1:0]    data_out_ser;
    logic [MODE-1:0]     clk_out_ser;
    logic                pixel_clk_en;
    logic                underflow;
    logic [UW-1:0]       underflow_cnt;

    int checks = 0;
    int errors = 0;

    logic [W-1:0]            rx_q[$];
    logic [LANES-1:0][6:0]   sh;
    int                      bitpos = -1;

    cameralink_n_x_7to1_sdr_tx #(
        .CAMERALINK_MODE(MODE),
        .CAMERALINK_CHAL(CHAL),
        .UFLOW_CNT_W(UW)
    ) dut (
        .ser_clk_in(ser_clk_in),
        .reset_n(reset_n),
        .tx_en(tx_en),
        .data_in(data_in),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .data_out_ser(data_out_ser),
        .clk_out_ser(clk_out_ser),
        .pixel_clk_en(pixel_clk_en),
        .underflow(underflow),
        .underflow_cnt(underflow_cnt)
    );

    always #5 ser_clk_in = ~ser_clk_in;

    // Receiver model: a word starts on the pixel_clk_en cycle, MSB first per lane.
    always @(negedge ser_clk_in) begin
        if (!reset_n) begin
            bitpos = -1;
        end else begin
            if (pixel_clk_en) bitpos = 0;
            if (bitpos >= 0) begin
                for (int k = 0; k < LANES; k++) sh[k] = {sh[k][5:0], data_out_ser[k]};
                bitpos++;
                if (bitpos == 7) begin
                    rx_q.push_back(sh);
                    bitpos = -1;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] pattern(input int i);
        return W'(32'h0A1B2C3 + i * 32'h0111111);
    endfunction

    // Leaves the bench at the negedge where reset is released; the next posedge is phase 0.
    task automatic reset_dut(input logic en);
        @(negedge ser_clk_in);
        reset_n    = 1'b0;
        data_valid = 1'b0;
        data_in    = '0;
        tx_en      = en;
        repeat (2) @(negedge ser_clk_in);
        rx_q.delete();
        reset_n = 1'b1;
    endtask

    task automatic wait_words(input int n, input int budget, input string tag);
        int b;
        b = 0;
        #1;
        while (rx_q.size() < n && b < budget) begin
            @(negedge ser_clk_in);
            #1;
            b++;
        end
        checks++;
        if (rx_q.size() < n) begin
            errors++;
            $display("FAIL %s_words: got %0d words want %0d", tag, rx_q.size(), n);
        end
    endtask

    task automatic test_reset();
        logic [6:0] p;
        reset_dut(1'b1);
        for (int c = 0; c < 15; c++) begin
            data_valid = (c == 8) || (c == 9) || (c == 14);
            data_in    = (c == 8) ? 28'hFFFFFFF : (c == 9) ? 28'h0F0F0F0 : (c == 14) ? 28'h3333333 : '0;
            @(negedge ser_clk_in);
        end
        data_valid = 1'b0;
        checks++;
        if (data_ready !== 1'b0) begin errors++; $display("FAIL pre_reset_ready: got %b want 0", data_ready); end
        checks++;
        if (data_out_ser !== 4'hF) begin errors++; $display("FAIL pre_reset_data: got %h want f", data_out_ser); end
        checks++;
        if (underflow_cnt !== 2'd1) begin errors++; $display("FAIL pre_reset_ucnt: got %0d want 1", underflow_cnt); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (data_out_ser !== '0) begin errors++; $display("FAIL rst_data: got %h want 0", data_out_ser); end
        checks++;
        if (clk_out_ser !== '0) begin errors++; $display("FAIL rst_clk: got %b want 0", clk_out_ser); end
        checks++;
        if (pixel_clk_en !== 1'b0) begin errors++; $display("FAIL rst_pix: got %b want 0", pixel_clk_en); end
        checks++;
        if (underflow !== 1'b0 || underflow_cnt !== '0) begin
            errors++; $display("FAIL rst_uflow: got %b/%0d want 0/0", underflow, underflow_cnt);
        end
        checks++;
        if (data_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", data_ready); end
        @(negedge ser_clk_in);
        @(negedge ser_clk_in);
        reset_n = 1'b1;
        p = 7'b1100011;
        for (int i = 0; i < 14; i++) begin
            @(negedge ser_clk_in);
            checks++;
            if (clk_out_ser !== {MODE{p[6]}}) begin
                errors++; $display("FAIL clk_lane[%0d]: got %b want %b", i, clk_out_ser, p[6]);
            end
            checks++;
            if (pixel_clk_en !== ((i % 7) == 0)) begin
                errors++; $display("FAIL pix_strobe[%0d]: got %b want %b", i, pixel_clk_en, (i % 7) == 0);
            end
            checks++;
            if (data_out_ser !== '0) begin
                errors++; $display("FAIL post_rst_data[%0d]: got %h want 0", i, data_out_ser);
            end
            if (i == 6) begin
                checks++;
                if (underflow !== 1'b1 || underflow_cnt !== 2'd1) begin
                    errors++; $display("FAIL fifo_flushed: got %b/%0d want 1/1", underflow, underflow_cnt);
                end
            end
            p = {p[5:0], p[6]};
        end
        tx_en = 1'b0;
    endtask

    task automatic test_single_word();
        logic [6:0] l0;
        l0 = 7'b0000001;
        reset_dut(1'b1);
        for (int c = 0; c < 14; c++) begin
            data_valid = (c == 0);
            data_in    = (c == 0) ? 28'h5AC3F01 : '0;
            @(negedge ser_clk_in);
            if (c + 1 == 7) begin
                checks++;
                if (underflow !== 1'b0) begin errors++; $display("FAIL sw_no_uflow: got %b want 0", underflow); end
            end
            if (c + 1 == 8) begin
                checks++;
                if (pixel_clk_en !== 1'b1) begin errors++; $display("FAIL sw_latency: got %b want 1", pixel_clk_en); end
            end
            if (c + 1 >= 8) begin
                checks++;
                if (data_out_ser[0] !== l0[6]) begin
                    errors++; $display("FAIL sw_lane0[%0d]: got %b want %b", c - 7, data_out_ser[0], l0[6]);
                end
                l0 = {l0[5:0], 1'b0};
            end
        end
        checks++;
        if (underflow !== 1'b1 || underflow_cnt !== 2'd1) begin
            errors++; $display("FAIL sw_next_uflow: got %b/%0d want 1/1", underflow, underflow_cnt);
        end
        wait_words(2, 10, "sw");
        checks++;
        if (rx_q[1] !== 28'h5AC3F01) begin errors++; $display("FAIL sw_word: got %h want 5ac3f01", rx_q[1]); end
        tx_en = 1'b0;
    endtask

    task automatic test_underflow();
        reset_dut(1'b1);
        for (int c = 0; c < 35; c++) begin
            @(negedge ser_clk_in);
            if (c + 1 == 6) begin
                checks++;
                if (underflow !== 1'b0) begin errors++; $display("FAIL uf_early: got %b want 0", underflow); end
            end
            if (c + 1 == 7) begin
                checks++;
                if (underflow !== 1'b1 || underflow_cnt !== 2'd1) begin
                    errors++; $display("FAIL uf_first: got %b/%0d want 1/1", underflow, underflow_cnt);
                end
            end
            if (c + 1 == 14) begin
                checks++;
                if (underflow_cnt !== 2'd2) begin errors++; $display("FAIL uf_cnt2: got %0d want 2", underflow_cnt); end
            end
            if (c + 1 == 21 || c + 1 == 28 || c + 1 == 35) begin
                checks++;
                if (underflow_cnt !== 2'd3) begin
                    errors++; $display("FAIL uf_sat@%0d: got %0d want 3", c + 1, underflow_cnt);
                end
            end
        end
        wait_words(4, 10, "uf");
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (rx_q[i] !== '0) begin errors++; $display("FAIL uf_idle[%0d]: got %h want 0", i, rx_q[i]); end
        end
        tx_en = 1'b0;
    endtask

    task automatic test_enable_gating();
        reset_dut(1'b0);
        for (int c = 0; c < 35; c++) begin
            data_valid = (c == 0) || (c == 1);
            data_in    = (c == 0) ? 28'h1234567 : (c == 1) ? 28'h7654321 : '0;
            @(negedge ser_clk_in);
            if (c + 1 == 2) begin
                checks++;
                if (data_ready !== 1'b0) begin errors++; $display("FAIL eg_full: got %b want 0", data_ready); end
            end
            if (c + 1 == 14) begin
                checks++;
                if (underflow !== 1'b0) begin errors++; $display("FAIL eg_no_uflow: got %b want 0", underflow); end
                tx_en = 1'b1;
            end
            if (c + 1 == 21) begin
                checks++;
                if (data_ready !== 1'b1) begin errors++; $display("FAIL eg_popped: got %b want 1", data_ready); end
            end
            if (c + 1 == 34) begin
                checks++;
                if (underflow !== 1'b0) begin errors++; $display("FAIL eg_no_uflow2: got %b want 0", underflow); end
            end
        end
        tx_en = 1'b0;
        wait_words(5, 10, "eg");
        checks++;
        if (rx_q[2] !== '0) begin errors++; $display("FAIL eg_idle: got %h want 0", rx_q[2]); end
        checks++;
        if (rx_q[3] !== 28'h1234567) begin errors++; $display("FAIL eg_word0: got %h want 1234567", rx_q[3]); end
        checks++;
        if (rx_q[4] !== 28'h7654321) begin errors++; $display("FAIL eg_word1: got %h want 7654321", rx_q[4]); end
    endtask

    task automatic test_simultaneous();
        reset_dut(1'b1);
        for (int c = 0; c < 35; c++) begin
            data_valid = (c == 0) || (c == 2) || (c == 13) || (c == 14);
            data_in    = (c == 0) ? 28'h0000AAA : (c == 2) ? 28'h0000BBB :
                         (c == 13) ? 28'h0000CCC : (c == 14) ? 28'h0000DDD : '0;
            @(negedge ser_clk_in);
            if (c + 1 == 14) begin
                checks++;
                if (data_ready !== 1'b1) begin errors++; $display("FAIL sim_count1: got %b want 1", data_ready); end
            end
            if (c + 1 == 15) begin
                checks++;
                if (data_ready !== 1'b0) begin errors++; $display("FAIL sim_count2: got %b want 0", data_ready); end
            end
            if (c + 1 == 34) begin
                checks++;
                if (underflow !== 1'b0) begin errors++; $display("FAIL sim_no_uflow: got %b want 0", underflow); end
            end
        end
        tx_en = 1'b0;
        wait_words(5, 10, "sim");
        checks++;
        if (rx_q[1] !== 28'h0000AAA) begin errors++; $display("FAIL sim_w0: got %h want 0000aaa", rx_q[1]); end
        checks++;
        if (rx_q[2] !== 28'h0000BBB) begin errors++; $display("FAIL sim_w1: got %h want 0000bbb", rx_q[2]); end
        checks++;
        if (rx_q[3] !== 28'h0000CCC) begin errors++; $display("FAIL sim_w2: got %h want 0000ccc", rx_q[3]); end
        checks++;
        if (rx_q[4] !== 28'h0000DDD) begin errors++; $display("FAIL sim_w3: got %h want 0000ddd", rx_q[4]); end
    endtask

    task automatic test_back_to_back();
        int   idx;
        logic acc;
        logic saw_low;
        idx     = 0;
        saw_low = 1'b0;
        reset_dut(1'b1);
        for (int cyc = 0; cyc < 170; cyc++) begin
            data_valid = (idx < 20);
            data_in    = pattern(idx);
            acc        = data_valid && data_ready;
            if (!data_ready) saw_low = 1'b1;
            @(negedge ser_clk_in);
            if (acc) idx++;
            if (cyc + 1 == 140) begin
                checks++;
                if (underflow !== 1'b0) begin errors++; $display("FAIL b2b_no_uflow: got %b want 0", underflow); end
            end
            #1;
            if (rx_q.size() >= 21) break;
        end
        data_valid = 1'b0;
        tx_en      = 1'b0;
        checks++;
        if (idx != 20) begin errors++; $display("FAIL b2b_accepted: got %0d want 20", idx); end
        checks++;
        if (saw_low !== 1'b1) begin errors++; $display("FAIL b2b_ready_drop: got %b want 1", saw_low); end
        checks++;
        if (rx_q.size() < 21) begin
            errors++; $display("FAIL b2b_words: got %0d want 21", rx_q.size());
        end else begin
            for (int i = 0; i < 20; i++) begin
                checks++;
                if (rx_q[i + 1] !== pattern(i)) begin
                    errors++; $display("FAIL b2b_word[%0d]: got %h want %h", i, rx_q[i + 1], pattern(i));
                end
            end
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        tx_en      = 1'b0;
        data_valid = 1'b0;
        data_in    = '0;
        test_reset();
        test_single_word();
        test_underflow();
        test_enable_gating();
        test_simultaneous();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
